// File: rtl/key_counter_ctrl.sv
// Purpose: debounce two active-low keys and load/hex switches into a 5-bit up/down value plus display mode.
// Latency: a held key changes count DB_CYCLES+2 edges after the raw low is first sampled; switches take 3 edges.
// Backpressure: none; free-running control stage with no handshake, and every edge is evaluated.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   key_up_n, key_dn_n  raw active-low pushbuttons (increment / decrement)
//   sw_load, sw_val     raw load switch and 5-bit load value
//   sw_hex              raw display-mode switch
//   count               current value for the decoder value input
//   con                 display mode, 1 = hex, 0 = decimal
//   wrap_flag           one-cycle pulse on a wrap or on a blocked saturated step

// Per-key 2-FF synchronizer and debouncer. It emits a single-cycle press
// pulse on the same edge that the stable state falls from 1 to 0.
module key_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw_n;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press    = 1'b0;
    if (s2_q != stable_q) begin
      // DB_CYCLES consecutive mismatching samples are needed before the
      // stable state follows; any matching sample restarts the count.
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
        cnt_d    = '0;
        press    = stable_q & ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module key_counter_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int WRAP      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up_n,
  input  logic       key_dn_n,
  input  logic       sw_load,
  input  logic [4:0] sw_val,
  input  logic       sw_hex,
  output logic [4:0] count,
  output logic       con,
  output logic       wrap_flag
);
  logic       up_ev;
  logic       dn_ev;

  // Switch synchronizer bundle: {sw_hex, sw_load, sw_val[4:0]}.
  logic [6:0] sw_s1_q, sw_s1_d;
  logic [6:0] sw_s2_q, sw_s2_d;
  logic [4:0] count_q, count_d;
  logic       wrap_q, wrap_d;
  logic       con_q, con_d;

  logic       load_s;
  logic [4:0] val_s;
  logic       hex_s;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (key_up_n),
    .press (up_ev)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (key_dn_n),
    .press (dn_ev)
  );

  assign hex_s  = sw_s2_q[6];
  assign load_s = sw_s2_q[5];
  assign val_s  = sw_s2_q[4:0];

  always_comb begin
    sw_s1_d = {sw_hex, sw_load, sw_val};
    sw_s2_d = sw_s1_q;
    con_d   = hex_s;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_s) begin
      // Loading overrides the keys; press events arriving now are lost.
      count_d = val_s;
    end else if (up_ev && dn_ev) begin
      count_d = count_q;
    end else if (up_ev) begin
      if (count_q == 5'd31) begin
        wrap_d  = 1'b1;
        count_d = (WRAP != 0) ? 5'd0 : 5'd31;
      end else begin
        count_d = count_q + 5'd1;
      end
    end else if (dn_ev) begin
      if (count_q == 5'd0) begin
        wrap_d  = 1'b1;
        count_d = (WRAP != 0) ? 5'd31 : 5'd0;
      end else begin
        count_d = count_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      con_q   <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      con_q   <= con_d;
    end
  end

  assign count     = count_q;
  assign wrap_flag = wrap_q;
  assign con       = con_q;
endmodule

// File: doc/key_counter_ctrl.md
Name: key_counter_ctrl

Overview:
- Front-end control stage for the two-digit 7-segment display path.
- Converts the raw active-low pushbuttons and slide switches into a debounced 5-bit value (0–31) and a display-mode bit.
- `count` drives the decoder's 5-bit value input `I`.
- `con` drives the decoder's mode input: 1 = hex display, 0 = decimal display.

Parameters:
- DB_CYCLES, default 500000: number of consecutive stable synchronized samples needed to accept a key transition (10 ms at 50 MHz). Minimum 2.
- WRAP, default 1: 1 = count wraps modulo 32; 0 = count saturates at 0 and 31.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_up_n  in  1  raw pushbutton, active-low, asynchronous; increment.
- key_dn_n  in  1  raw pushbutton, active-low, asynchronous; decrement.
- sw_load  in  1  raw switch, active-high; load sw_val.
- sw_val  in  5  raw switches; load value.
- sw_hex  in  1  raw switch; display mode request.
- count  out  5  current value; feeds decoder `I`.
- con  out  1  display mode; 1 = hex, 0 = decimal.
- wrap_flag  out  1  one-cycle pulse on wrap or on a saturated (blocked) step.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - count=0, con=0, wrap_flag=0.
  - Key synchronizers and debounced key states = 1 (released).
  - Switch synchronizers = 0; debounce counters = 0.
- Synchronization: every raw input passes a 2-FF synchronizer. Only synchronized versions (s2) are used downstream.
- Debounce, per key, independent:
  - 0..DB_CYCLES-1 counter compares s2 with the stable state.
  - On a mismatch edge: if counter == DB_CYCLES-1, stable takes s2 and counter clears; otherwise counter increments.
  - On a match edge: counter clears.
  - A glitch shorter than DB_CYCLES samples never changes stable.
- Press event: stable transitions 1->0, asserted on the same edge stable updates. Releases (0->1) produce no event. A held key gives exactly one event.
- Latency: raw key low first sampled at edge 1 and held -> count changes at edge DB_CYCLES+2.
- Update priority, evaluated each edge:
  1. Synchronized sw_load=1: count <= synced sw_val every edge. Press events are discarded. wrap_flag=0.
  2. Up and down events on the same edge: count unchanged, wrap_flag=0.
  3. Up event: count+1.
  4. Down event: count-1.
  5. Otherwise hold.
- Arithmetic: 5-bit unsigned.
  - WRAP=1: 31+1 -> 0 and 0-1 -> 31, with wrap_flag=1 for that single cycle.
  - WRAP=0: the step is blocked at 31 (up) or 0 (down), count holds, wrap_flag=1 for one cycle.
  - wrap_flag is 0 on all other edges.
- con: registered copy of synchronized sw_hex, 3 edges after the raw change. Mode changes never alter count.
- Reset mid-debounce: all progress discarded. A key still held when rst_n deasserts is treated as a new press and counts after DB_CYCLES+2 edges.
- sw_load deassertion: counting resumes from the loaded value. A key held across the load does not generate a second event.

Test Plan (DB_CYCLES=4, WRAP=1 unless stated):
- Reset, then key_up_n low for 20 cycles -> count 0->1 exactly at edge 6 after the first low sample; no further change while held; wrap_flag stays 0.
- key_up_n low pulses of 3 cycles, repeated every 6 cycles for 60 cycles -> count stays 0.
- Load: sw_val=31, sw_load=1 for 5 cycles, then release; then one up press -> count=31, then 0 with a 1-cycle wrap_flag. A following down press -> 31 with wrap_flag.
- WRAP=0, count=0, down press -> count stays 0, wrap_flag pulses once. Load 31, up press -> stays 31, wrap_flag pulses.
- Both keys pressed in the same raw cycle -> no count change, wrap_flag 0. While sw_load=1 with sw_val=7, an up press -> count remains 7.
- sw_hex 0->1 -> con=1 at edge 3, count unchanged. Assert rst_n=0 mid-debounce (counter at 2) -> count=0 and con=0 immediately; a key held through reset increments at edge 6 after rst_n release.
